// File: rtl/button_gesture_decoder.sv
// Turns debounced press/release pulses into short, long, double-click and auto-repeat gesture pulses.
// Optional auto-repeat is compiled in with `define GESTURE_REPEAT_EN.
module button_gesture_decoder #(
    parameter int LONG_TICKS   = 50_000_000,
    parameter int DCLICK_TICKS = 25_000_000,
    parameter int REPEAT_TICKS = 10_000_000,
    parameter int CW           = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic pressed_pulse,
    input  logic released_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HELD,
        S_LONG_HELD,
        S_WAIT_SECOND,
        S_SECOND_HELD
    } state_t;

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_TICKS - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_short;
    logic          r_long;
    logic          r_double;
    logic          r_held;

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pressed_pulse) begin
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                        r_held  <= 1'b1;
                    end
                end
                S_HELD: begin
                    // A release on the terminal-count edge takes the short path.
                    if (released_pulse) begin
                        r_state <= S_WAIT_SECOND;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                    end else if (r_cnt == LONG_LAST) begin
                        r_state <= S_LONG_HELD;
                        r_cnt   <= '0;
                        r_long  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LONG_HELD: begin
                    if (released_pulse) begin
                        r_state <= S_IDLE;
                        r_held  <= 1'b0;
                    end
                end
                S_WAIT_SECOND: begin
                    // A press on the terminal-count edge still becomes a double click.
                    if (pressed_pulse) begin
                        r_state <= S_SECOND_HELD;
                        r_cnt   <= '0;
                        r_held  <= 1'b1;
                    end else if (r_cnt == DCLICK_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_short <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SECOND_HELD: begin
                    if (released_pulse) begin
                        r_state  <= S_IDLE;
                        r_held   <= 1'b0;
                        r_double <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GESTURE_REPEAT_EN
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);

    logic [CW-1:0] r_rcnt;
    logic          r_repeat;

    // Repeat counter runs only while in LONG_HELD; a coincident release suppresses the pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rcnt   <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (r_state == S_LONG_HELD && !released_pulse) begin
                if (r_rcnt == REPEAT_LAST) begin
                    r_rcnt   <= '0;
                    r_repeat <= 1'b1;
                end else begin
                    r_rcnt <= r_rcnt + 1'b1;
                end
            end else begin
                r_rcnt <= '0;
            end
        end
    end

    assign repeat_pulse = r_repeat;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_click = r_double;
    assign held         = r_held;

endmodule
